// File: rtl/divider_32_bit_pkg.sv
// Shared definitions for the multi-cycle restoring divider: state encoding,
// default width and the fixed latency the control unit stalls for.
package divider_32_bit_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/divider_32_bit_sub.sv
// Combinational W-bit subtractor (a - b) built on the parallel-prefix
// carry-lookahead add structure: b inverted, carry-in tied high.
module sub_33_bit #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int STAGES = $clog2(W);

  logic [W-1:0] bn;
  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic [W-1:0] g_acc;
  logic [W-1:0] p_acc;
  logic [W:0]   carry;

  always_comb begin
    bn    = ~b;
    gen   = a & bn;
    prop  = a ^ bn;
    g_acc = gen;
    p_acc = prop;
    // Kogge-Stone prefix; walking downward keeps each level's lower inputs intact
    for (int s = 0; s < STAGES; s++) begin
      for (int i = W - 1; i >= (1 << s); i--) begin
        g_acc[i] = g_acc[i] | (p_acc[i] & g_acc[i - (1 << s)]);
        p_acc[i] = p_acc[i] & p_acc[i - (1 << s)];
      end
    end
    carry[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      carry[i + 1] = g_acc[i] | p_acc[i];
    end
    diff   = prop ^ carry[W-1:0];
    borrow = ~carry[W];
  end

endmodule

// File: rtl/divider_32_bit.sv
// Multi-cycle restoring integer divider, signed or unsigned, one
// subtract-and-test per cycle; results held until the next accepted start.
module divider_32_bit
  import divider_32_bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divZero
);

  div_state_t       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] p_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;

  // Trial subtract of the shifted partial remainder against the divisor
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;

  assign shifted = {p_reg[WIDTH-2:0], a_reg[WIDTH-1]};

  sub_33_bit #(.W(WIDTH + 1)) u_trial (
    .a      ({1'b0, shifted}),
    .b      ({1'b0, d_reg}),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // Two negators shared between operand magnitude (IDLE) and result sign fix (FIX)
  logic [WIDTH-1:0] neg_a_in;
  logic [WIDTH-1:0] neg_b_in;
  logic [WIDTH:0]   neg_a_out;
  logic [WIDTH:0]   neg_b_out;
  logic             neg_a_borrow;
  logic             neg_b_borrow;

  assign neg_a_in = (state_reg == IDLE) ? dividend : a_reg;
  assign neg_b_in = (state_reg == IDLE) ? divisor  : p_reg;

  sub_33_bit #(.W(WIDTH + 1)) u_neg_a (
    .a      ('0),
    .b      ({1'b0, neg_a_in}),
    .diff   (neg_a_out),
    .borrow (neg_a_borrow)
  );

  sub_33_bit #(.W(WIDTH + 1)) u_neg_b (
    .a      ('0),
    .b      ({1'b0, neg_b_in}),
    .diff   (neg_b_out),
    .borrow (neg_b_borrow)
  );

  logic             dd_neg;
  logic             dv_neg;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;
  logic             div_last;
  logic             unused_bits;

  assign dd_neg   = isSigned & dividend[WIDTH-1];
  assign dv_neg   = isSigned & divisor[WIDTH-1];
  assign dd_mag   = dd_neg ? neg_a_out[WIDTH-1:0] : dividend;
  assign dv_mag   = dv_neg ? neg_b_out[WIDTH-1:0] : divisor;
  assign div_last = (cnt_reg == CNT_W'(WIDTH - 1));

  assign unused_bits = ^{trial_diff[WIDTH], neg_a_out[WIDTH], neg_b_out[WIDTH],
                         neg_a_borrow, neg_b_borrow};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      d_reg     <= '0;
      p_reg     <= '0;
      cnt_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divZero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= dd_mag;
            d_reg     <= dv_mag;
            p_reg     <= '0;
            cnt_reg   <= '0;
            neg_q_reg <= dd_neg ^ dv_neg;
            neg_r_reg <= dd_neg;
            divZero   <= 1'b0;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              divZero   <= 1'b1;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              busy      <= 1'b1;
              state_reg <= DIV;
            end
          end
        end
        DIV: begin
          p_reg   <= trial_borrow ? shifted : trial_diff[WIDTH-1:0];
          a_reg   <= {a_reg[WIDTH-2:0], ~trial_borrow};
          cnt_reg <= cnt_reg + 1'b1;
          if (div_last) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          quotient  <= neg_q_reg ? neg_a_out[WIDTH-1:0] : a_reg;
          remainder <= neg_r_reg ? neg_b_out[WIDTH-1:0] : p_reg;
          busy      <= 1'b0;
          done      <= 1'b1;
          state_reg <= DONE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_32_bit.sv
// Directed-vector bench for divider_32_bit: results, latency, divide-by-zero,
// signed overflow, ignored starts and mid-operation reset.
module tb_divider_32_bit;
  import divider_32_bit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        isSigned;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divZero;

  int checks = 0;
  int passed = 0;
  int n;
  int pulses;

  always #5 clk = ~clk;

  divider_32_bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .isSigned  (isSigned),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .divZero   (divZero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  // Call in IDLE, #1 after a rising edge; returns #1 after the cycle following DONE.
  task automatic run_div(input string tag, input bit sgn, input logic [31:0] dd,
                         input logic [31:0] dv, input logic [31:0] eq,
                         input logic [31:0] er, input bit edz, input int elat);
    int cyc;
    isSigned = sgn; dividend = dd; divisor = dv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    if (elat > 1) check({tag, ".busy_c1"}, 32'(busy), 32'd1);
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(elat));
    check({tag, ".quotient"}, quotient, eq);
    check({tag, ".remainder"}, remainder, er);
    check({tag, ".divZero"}, 32'(divZero), 32'(edz));
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    $display("div %s: 0x%08h / 0x%08h signed=%0d -> q=0x%08h r=0x%08h dz=%0d at cycle %0d",
             tag, dd, dv, sgn, quotient, remainder, divZero, cyc);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; isSigned = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.quotient", quotient, 32'd0);
    check("reset.remainder", remainder, 32'd0);
    check("reset.divZero", 32'(divZero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, DIV_LATENCY);
    run_div("s-100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, DIV_LATENCY);
    run_div("s100_-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, DIV_LATENCY);
    run_div("divzero", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, DIV_LATENCY);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, DIV_LATENCY);
    run_div("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, DIV_LATENCY);

    // Starts while busy and while done is high must be ignored
    isSigned = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    for (n = 1; n <= 35; n++) begin
      if (n == 3 || n == 34 || n == 35) begin
        dividend = 32'd9; divisor = 32'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (n == 34) begin
        check("ign.done34", 32'(done), 32'd1);
        check("ign.quotient", quotient, 32'd10);
        check("ign.remainder", remainder, 32'd0);
      end
      if (n == 35) begin
        check("ign.done35", 32'(done), 32'd0);
        check("ign.busy35", 32'(busy), 32'd0);
        check("ign.held_q", quotient, 32'd10);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ign.busy_new", 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ign.latency2", 32'(n), 32'(DIV_LATENCY));
    check("ign.quotient2", quotient, 32'd4);
    check("ign.remainder2", remainder, 32'd1);
    $display("div ignore-start sequence: second result q=%0d r=%0d at cycle %0d", quotient, remainder, n);
    @(posedge clk); #1;

    // Reset in the middle of a divide aborts it with no done pulse
    isSigned = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (n = 1; n < 10; n++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.quotient", quotient, 32'd0);
    check("abort.remainder", remainder, 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort.no_done", 32'(pulses), 32'd0);
    $display("div abort: 1000/3 reset at cycle 10, done pulses afterwards=%0d", pulses);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
